// File: rtl/core_package.sv
// Shared CSR definitions for the RV32IM core: address map, Zicsr funct3
// encodings and mstatus/mip bit positions.
package core_package;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_INSTRETH  = 12'hC82,
        CSR_MHARTID   = 12'hF14
    } csr_e;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam int unsigned MSIP_BIT = 3;
    localparam int unsigned MTIP_BIT = 7;
    localparam int unsigned MEIP_BIT = 11;

    // The 0xC00-0xFFF block is read-only by encoding; mip is read-only here too.
    function automatic logic csr_read_only(input logic [11:0] addr);
        return (addr[11:10] == 2'b11) || (addr == CSR_MIP);
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Wide event counter written one XLEN-sized half at a time; a software
// write to either half takes precedence over that cycle's increment.
module csr_counter #(
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned LO_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [LO_WIDTH-1:0]  wdata,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[LO_WIDTH-1:0] <= wdata;
            if (wr_hi) count[CNT_WIDTH-1:LO_WIDTH] <= wdata[CNT_WIDTH-LO_WIDTH-1:0];
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write, counters, trap entry and
// mret. The old CSR value is returned one cycle after the request.
module csr_file
    import core_package::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CNT_WIDTH   = 64,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_valid_i,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [11:0]     csr_addr_i,
    input  logic            instret_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    input  logic [2:0]      irq_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            rvalid_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_global_o
);

    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h0000_0888);

    logic            status_mie;
    logic            status_mpie;
    logic [XLEN-1:0] mie_reg;
    logic [XLEN-1:0] mtvec_reg;
    logic [XLEN-1:0] mscratch_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mcause_reg;

    logic [CNT_WIDTH-1:0] mcycle;
    logic [CNT_WIDTH-1:0] minstret;

    logic [XLEN-1:0] src;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            known;
    logic            wr_intent;
    logic            illegal;
    logic            do_write;

    // rd selects only the pipeline's writeback target; the CSR file never needs it.
    logic unused_rd;
    assign unused_rd = ^rd;

    always_comb begin
        src       = funct3[2] ? {{(XLEN-5){1'b0}}, rs1} : rs1_data_i;
        wr_intent = (funct3[1:0] == 2'b01) || (rs1 != '0);
        known     = 1'b1;
        old_val   = '0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                old_val[MIE_BIT]  = status_mie;
                old_val[MPIE_BIT] = status_mpie;
            end
            CSR_MIE:      old_val = mie_reg;
            CSR_MTVEC:    old_val = mtvec_reg;
            CSR_MSCRATCH: old_val = mscratch_reg;
            CSR_MEPC:     old_val = mepc_reg;
            CSR_MCAUSE:   old_val = mcause_reg;
            CSR_MIP: begin
                old_val[MEIP_BIT] = irq_i[2];
                old_val[MTIP_BIT] = irq_i[1];
                old_val[MSIP_BIT] = irq_i[0];
            end
            CSR_MCYCLE, CSR_CYCLE:       old_val = mcycle[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH:     old_val = XLEN'(mcycle[CNT_WIDTH-1:XLEN]);
            CSR_MINSTRET, CSR_INSTRET:   old_val = minstret[XLEN-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_val = XLEN'(minstret[CNT_WIDTH-1:XLEN]);
            CSR_MHARTID:  old_val = HART_ID;
            default:      known   = 1'b0;
        endcase

        case (funct3[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase

        illegal  = !known || (funct3[1:0] == 2'b00) || (wr_intent && csr_read_only(csr_addr_i));
        do_write = csr_valid_i && !illegal && wr_intent && !trap_i && !mret_i;
    end

    csr_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .LO_WIDTH  (XLEN)
    ) u_mcycle (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (do_write && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi (do_write && (csr_addr_i == CSR_MCYCLEH)),
        .wdata (new_val),
        .count (mcycle)
    );

    csr_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .LO_WIDTH  (XLEN)
    ) u_minstret (
        .clk   (clk),
        .reset (reset),
        .inc   (instret_i),
        .wr_lo (do_write && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi (do_write && (csr_addr_i == CSR_MINSTRETH)),
        .wdata (new_val),
        .count (minstret)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            status_mie   <= 1'b0;
            status_mpie  <= 1'b0;
            mie_reg      <= '0;
            mtvec_reg    <= MTVEC_RESET;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            rdata_o      <= '0;
            rvalid_o     <= 1'b0;
            illegal_o    <= 1'b0;
        end else begin
            rvalid_o  <= csr_valid_i;
            illegal_o <= csr_valid_i && illegal;
            if (csr_valid_i) rdata_o <= illegal ? '0 : old_val;

            if (trap_i) begin
                mepc_reg    <= trap_pc_i & ~XLEN'(3);
                mcause_reg  <= trap_cause_i;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else if (mret_i) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
            end else if (do_write) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        status_mie  <= new_val[MIE_BIT];
                        status_mpie <= new_val[MPIE_BIT];
                    end
                    CSR_MIE:      mie_reg      <= new_val & MIE_MASK;
                    CSR_MTVEC:    mtvec_reg    <= new_val & ~XLEN'(3);
                    CSR_MSCRATCH: mscratch_reg <= new_val;
                    CSR_MEPC:     mepc_reg     <= new_val & ~XLEN'(3);
                    CSR_MCAUSE:   mcause_reg   <= new_val;
                    default: ;
                endcase
            end
        end
    end

    assign mtvec_o      = mtvec_reg;
    assign mepc_o       = mepc_reg;
    assign mie_global_o = status_mie;

endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file against an architectural model of the
// machine-mode CSR state, plus directed scenarios with hand-derived values.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_valid_i;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] rs1_data_i;
    logic [11:0] csr_addr_i;
    logic        instret_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic        mret_i;
    logic [2:0]  irq_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        illegal_o;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_global_o;

    int checks   = 0;
    int failures = 0;

    csr_file #(
        .XLEN        (32),
        .CNT_WIDTH   (64),
        .HART_ID     (32'd0),
        .MTVEC_RESET (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .csr_valid_i  (csr_valid_i),
        .funct3       (funct3),
        .rd           (rd),
        .rs1          (rs1),
        .rs1_data_i   (rs1_data_i),
        .csr_addr_i   (csr_addr_i),
        .instret_i    (instret_i),
        .trap_i       (trap_i),
        .trap_cause_i (trap_cause_i),
        .trap_pc_i    (trap_pc_i),
        .mret_i       (mret_i),
        .irq_i        (irq_i),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .illegal_o    (illegal_o),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mie_global_o (mie_global_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural state of the model
    bit          m_mie_g, m_mpie;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_inst;

    function automatic bit m_read(input logic [11:0] a, input logic [2:0] iq, output logic [31:0] v);
        v = 32'h0;
        case (a)
            12'h300: v = (m_mie_g ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h344: v = (iq[2] ? 32'h800 : 32'h0) | (iq[1] ? 32'h80 : 32'h0) | (iq[0] ? 32'h8 : 32'h0);
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_inst[31:0];
            12'hB82, 12'hC82: v = m_inst[63:32];
            12'hF14: v = 32'h0;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic op(input bit rst, input bit v, input logic [2:0] f3, input logic [4:0] r1,
                      input logic [31:0] d, input logic [11:0] a, input bit ir, input bit tr,
                      input logic [31:0] tc, input logic [31:0] tp, input bit mr, input logic [2:0] iq);
        logic [31:0] src, old, nv;
        bit known, wr, ro, ill, commit;
        bit exp_valid, exp_ill;
        logic [31:0] exp_rdata;

        reset = rst; csr_valid_i = v; funct3 = f3; rd = 5'd1; rs1 = r1; rs1_data_i = d;
        csr_addr_i = a; instret_i = ir; trap_i = tr; trap_cause_i = tc; trap_pc_i = tp;
        mret_i = mr; irq_i = iq;

        src   = f3[2] ? {27'b0, r1} : d;
        wr    = (f3[1:0] == 2'b01) || (r1 != 5'd0);
        known = m_read(a, iq, old);
        ro    = (a[11:10] == 2'b11) || (a == 12'h344);
        ill   = !known || (f3[1:0] == 2'b00) || (wr && ro);
        case (f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            default: nv = old & ~src;
        endcase
        exp_valid = !rst && v;
        exp_ill   = ill;
        exp_rdata = ill ? 32'h0 : old;

        if (rst) begin
            m_mie_g = 0; m_mpie = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_cyc = 0; m_inst = 0;
        end else begin
            commit = v && !ill && wr && !tr && !mr;
            if (commit && a == 12'hB00)      m_cyc  = {m_cyc[63:32], nv};
            else if (commit && a == 12'hB80) m_cyc  = {nv, m_cyc[31:0]};
            else                             m_cyc  = m_cyc + 64'd1;
            if (commit && a == 12'hB02)      m_inst = {m_inst[63:32], nv};
            else if (commit && a == 12'hB82) m_inst = {nv, m_inst[31:0]};
            else if (ir)                     m_inst = m_inst + 64'd1;
            if (tr) begin
                m_mepc = tp & ~32'h3; m_mcause = tc; m_mpie = m_mie_g; m_mie_g = 0;
            end else if (mr) begin
                m_mie_g = m_mpie; m_mpie = 1;
            end else if (commit) begin
                case (a)
                    12'h300: begin m_mie_g = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_mie      = nv & 32'h888;
                    12'h305: m_mtvec    = nv & ~32'h3;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc     = nv & ~32'h3;
                    12'h342: m_mcause   = nv;
                    default: ;
                endcase
            end
        end

        @(posedge clk);
        #1;
        check("rvalid", 64'(rvalid_o), 64'(exp_valid));
        if (exp_valid) begin
            check("rdata", 64'(rdata_o), 64'(exp_rdata));
            check("illegal", 64'(illegal_o), 64'(exp_ill));
        end
        check("mtvec_o", 64'(mtvec_o), 64'(m_mtvec));
        check("mepc_o", 64'(mepc_o), 64'(m_mepc));
        check("mie_global", 64'(mie_global_o), 64'(m_mie_g));
    endtask

    task automatic csr(input logic [2:0] f3, input logic [4:0] r1, input logic [31:0] d, input logic [11:0] a);
        op(0, 1, f3, r1, d, a, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic idle();
        op(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    initial begin
        logic [11:0] addrs [18];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB02,
                  12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14, 12'h7FF, 12'h123};

        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        op(1, 1, 3'b001, 5'd1, 32'h1, 12'h340, 0, 0, 0, 0, 0, 0);
        check("reset_rdata", 64'(rdata_o), 64'h0);
        check("reset_illegal", 64'(illegal_o), 64'h0);

        // mscratch RW then read-only RS
        csr(3'b001, 5'd1, 32'hDEAD_BEEF, 12'h340);
        check("rw_old", 64'(rdata_o), 64'h0);
        csr(3'b010, 5'd0, 32'hFFFF_FFFF, 12'h340);
        check("rs0_read", 64'(rdata_o), 64'hDEAD_BEEF);
        csr(3'b010, 5'd0, 32'h0, 12'h340);
        check("rs0_nowrite", 64'(rdata_o), 64'hDEAD_BEEF);

        // CSRRCI uimm=0 must not write; CSRRC with rs1!=0 clears
        csr(3'b001, 5'd2, 32'h0000_FF00, 12'h340);
        csr(3'b111, 5'd0, 32'hFFFF_FFFF, 12'h340);
        csr(3'b011, 5'd3, 32'h0000_0F00, 12'h340);
        check("rci0_nowrite", 64'(rdata_o), 64'h0000_FF00);
        csr(3'b010, 5'd0, 32'h0, 12'h340);
        check("rc_clear", 64'(rdata_o), 64'h0000_F000);

        // mcycle carry into the high half
        csr(3'b001, 5'd1, 32'hFFFF_FFFF, 12'hB00);
        csr(3'b010, 5'd0, 32'h0, 12'hB00);
        check("mcycle_pre", 64'(rdata_o), 64'hFFFF_FFFF);
        csr(3'b010, 5'd0, 32'h0, 12'hB00);
        check("mcycle_wrap", 64'(rdata_o), 64'h0);
        csr(3'b010, 5'd0, 32'h0, 12'hB80);
        check("mcycleh_carry", 64'(rdata_o), 64'h1);
        csr(3'b001, 5'd1, 32'h0000_0100, 12'hB00);
        csr(3'b010, 5'd0, 32'h0, 12'hB00);
        check("mcycle_wr_wins", 64'(rdata_o), 64'h100);

        // Illegal accesses
        csr(3'b001, 5'd1, 32'h55, 12'hC00);
        check("ro_write_ill", 64'(illegal_o), 64'h1);
        check("ro_write_data", 64'(rdata_o), 64'h0);
        csr(3'b010, 5'd1, 32'h1, 12'h7FF);
        check("unknown_ill", 64'(illegal_o), 64'h1);
        csr(3'b010, 5'd0, 32'h0, 12'hC00);
        check("cycle_read_ok", 64'(illegal_o), 64'h0);
        csr(3'b000, 5'd0, 32'h0, 12'h340);
        check("f3_000_ill", 64'(illegal_o), 64'h1);

        // Trap with concurrent mepc write, then mret
        csr(3'b110, 5'd8, 32'h0, 12'h300);
        check("mie_set", 64'(mie_global_o), 64'h1);
        op(0, 1, 3'b001, 5'd1, 32'h5555_5555, 12'h341, 0, 1, 32'h8000_000B, 32'h0000_1236, 0, 0);
        check("trap_mepc", 64'(mepc_o), 64'h1234);
        check("trap_mie", 64'(mie_global_o), 64'h0);
        csr(3'b010, 5'd0, 32'h0, 12'h342);
        check("trap_mcause", 64'(rdata_o), 64'h8000_000B);
        csr(3'b010, 5'd0, 32'h0, 12'h300);
        check("trap_mstatus", 64'(rdata_o), 64'h80);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        csr(3'b010, 5'd0, 32'h0, 12'h300);
        check("mret_mstatus", 64'(rdata_o), 64'h88);

        // Reset landing on a request
        op(1, 1, 3'b001, 5'd1, 32'h1234_5678, 12'h340, 0, 0, 0, 0, 0, 0);
        check("rst_drop_valid", 64'(rvalid_o), 64'h0);
        csr(3'b010, 5'd0, 32'h0, 12'hB00);
        check("rst_mcycle", 64'(rdata_o), 64'h0);
        csr(3'b010, 5'd0, 32'h0, 12'h340);
        check("rst_mscratch", 64'(rdata_o), 64'h0);

        for (int i = 0; i < 800; i++) begin
            logic [31:0] d;
            logic [4:0]  r1;
            d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            r1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            op($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, 3'($urandom), r1, d,
               addrs[$urandom_range(0, 17)], 1'($urandom), $urandom_range(0, 19) == 0,
               $urandom, $urandom, $urandom_range(0, 19) == 0, 3'($urandom));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the RV32IM core.
- Next generation of the core's CSR compute logic: stores the CSRs itself, applies full Zicsr read-modify-write semantics, and runs the cycle and retired-instruction counters.
- Flags illegal accesses and handles trap entry and mret.
- Sits beside the execute stage. The pipeline issues one CSR op per cycle and receives the old value one cycle later.

Parameters:
- XLEN, 32, data width of every CSR and of the rs1 data path.
- CNT_WIDTH, 64, width of mcycle/minstret; legal range 33..64, upper half read through the *h addresses.
- HART_ID, 0, constant returned by mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_valid_i  in  1  CSR instruction presented this cycle
- funct3  in  3  Zicsr op (core_package encodings)
- rd  in  5  destination register index
- rs1  in  5  rs1 index, or uimm for the *I forms
- rs1_data_i  in  XLEN  rs1 operand
- csr_addr_i  in  12  CSR address (core_package::csr_e)
- instret_i  in  1  one instruction retired this cycle
- trap_i  in  1  trap entry this cycle
- trap_cause_i  in  XLEN  mcause value for the trap
- trap_pc_i  in  XLEN  faulting PC
- mret_i  in  1  mret retiring
- irq_i  in  3  {MEIP, MTIP, MSIP} level inputs
- rdata_o  out  XLEN  old CSR value (registered)
- rvalid_o  out  1  rdata_o/illegal_o valid
- illegal_o  out  1  access was illegal
- mtvec_o  out  XLEN  current mtvec
- mepc_o  out  XLEN  current mepc
- mie_global_o  out  1  mstatus.MIE

Behaviour:
- **Reset** (sync, highest priority):
  - all CSRs 0, except mtvec=MTVEC_RESET and mstatus.MPIE=0.
  - rvalid_o=0, rdata_o=0, illegal_o=0.
  - Counters restart from 0, including when reset lands mid-operation; any in-flight request is dropped.
- **Implemented CSRs:**
  - mstatus (only MIE bit3 and MPIE bit7 writable; other bits read 0).
  - mie (bits 11,7,3 writable).
  - mip (read-only: bit11=irq_i[2], bit7=irq_i[1], bit3=irq_i[0]).
  - mtvec (bits[1:0] forced 0).
  - mscratch.
  - mepc (bits[1:0] forced 0).
  - mcause.
  - mcycle/mcycleh and minstret/minstreth (read-write).
  - cycle/cycleh and instret/instreth (read-only aliases).
  - mhartid (read-only).
- **Operand:** src = rs1_data_i for funct3[2]=0; src = {27'b0, rs1} for funct3[2]=1.
- **New value:**
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- **Write intent:**
  - RW/RWI always write.
  - RS/RC/RSI/RCI write only when rs1 field != 0. The rs1 data value is irrelevant to this decision.
- **Illegal** (no state change, illegal_o=1, rdata_o=0) when any of:
  - unknown address;
  - funct3 is 000 or 100;
  - write intent to a read-only address (csr_addr_i[11:10]==2'b11, or mip).
- **Latency:**
  - Request sampled at posedge N; the write commits at edge N.
  - rvalid_o=1 with rdata_o = value before edge N, during cycle N+1; otherwise rvalid_o=0.
  - Back-to-back ops are supported. The second op sees the first op's write.
- **Counters:**
  - mcycle +1 every non-reset cycle.
  - minstret +1 when instret_i=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - A software write to either half replaces that half and suppresses the increment in that cycle.
  - The read returns the pre-increment value.
  - Carry from the low half into the high half happens in the same cycle.
- **Trap** (trap_i=1):
  - mepc<=trap_pc_i&~3; mcause<=trap_cause_i; MPIE<=MIE; MIE<=0.
  - Any concurrent CSR write is discarded, but rvalid_o is still produced.
- **mret** (mret_i=1): MIE<=MPIE; MPIE<=1.
- **Priority:** trap_i over mret_i, and mret_i over a CSR write.

Decomposition:
- core_package:
  - csr_e address enum (adds mcycleh, minstreth, cycle*, instret*, mhartid);
  - funct3 constants CSRRW..CSRRCI;
  - mstatus bit-index localparams MIE_BIT=3, MPIE_BIT=7;
  - the read-only address predicate function.
- Sub-module csr_counter (CNT_WIDTH counter with inc, wr_lo, wr_hi, wdata), instantiated twice.

Test Plan:
- Reset, then CSRRW mscratch with rs1_data=32'hDEAD_BEEF, rd=1 -> next cycle rvalid_o=1, rdata_o=0. A following CSRRS with rs1=0 returns 32'hDEAD_BEEF and mscratch is unchanged.
- mscratch=32'hFF00, then CSRRCI with uimm=5'h0 -> no write. Then CSRRC with rs1_data=32'h0F00, rs1=3 -> mscratch=32'hF000.
- CSRRW mcycle with 32'hFFFF_FFFF -> two cycles later mcycle low=0 and mcycleh=1. A write and an increment in the same cycle keeps the written value.
- CSRRW cycle (0xC00), and a CSRRS to unknown 0x7FF with rs1=1 -> illegal_o=1, rdata_o=0, no state change. CSRRS cycle with rs1=0 -> legal.
- MIE=1, then trap_i with pc=32'h0000_1236 and cause=32'h8000_000B, plus a concurrent CSRRW mepc -> mepc=32'h1234, mcause=32'h8000_000B, MIE=0, MPIE=1. Then mret_i -> MIE=1, MPIE=1.
- Assert reset during a CSRRW request -> no write, rvalid_o=0 next cycle, mcycle=0.
